// File: rtl/bus_beat_packer.sv
// Packs narrow bus beats LSB-first into wide words and queues them in a
// first-word-fall-through FIFO presented on a valid/ready interface.
module bus_beat_packer #(
  parameter int unsigned BUS_W = 2,
  parameter int unsigned BEATS = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BUS_W-1:0]                 in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BUS_W*BEATS-1:0]           out_data,
  output logic [$clog2(BEATS+1)-1:0]       out_count,
  output logic [$clog2(DEPTH+1)-1:0]       level
);

  localparam int unsigned WORD_W = BUS_W * BEATS;
  localparam int unsigned CNT_W  = $clog2(BEATS + 1);
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  typedef enum logic [0:0] {EMPTY, PARTIAL} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d, cnt_inc;
  logic [WORD_W-1:0]   pack, pack_d, word_c;
  logic                accept, push, pop;

  logic [WORD_W-1:0]   mem_data [DEPTH];
  logic [CNT_W-1:0]    mem_cnt  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  assign in_ready  = !rst && (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign cnt_inc   = cnt + CNT_W'(1);

  // Empty FIFO drives zeros so the head never shows stale storage.
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_count = out_valid ? mem_cnt[rd_ptr]  : '0;

  // Merge the incoming beat into the pack register at the current position
  always_comb begin
    word_c = pack;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (CNT_W'(k) == cnt) word_c[k*BUS_W +: BUS_W] = in_data;
    end
  end

  // Packer next-state
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pack_d  = pack;
    push    = 1'b0;
    if (accept) begin
      push = in_last || (cnt_inc == CNT_W'(BEATS));
      if (push) begin
        cnt_d   = '0;
        pack_d  = '0;
        state_d = EMPTY;
      end else begin
        cnt_d   = cnt_inc;
        pack_d  = word_c;
        state_d = PARTIAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      cnt    <= '0;
      pack   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pack  <= pack_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents are qualified by level, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word_c;
      mem_cnt[wr_ptr]  <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_bus_beat_packer.sv
// Directed bench for bus_beat_packer with a queue scoreboard checked on every pop.
module tb_bus_beat_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [1:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic [2:0] level;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] c;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   stream = 1'b0;

  bus_beat_packer #(.BUS_W(2), .BEATS(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (stream) chk("stream_level_le1", 32'(level <= 3'd1), 32'd1);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        chk("beat_accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      step();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: compare every popped head against the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop_data", 32'(out_data), 32'(e.d));
        chk("pop_count", 32'(out_count), 32'(e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    step();

    // 1: full word, one-cycle latency, popped immediately
    out_ready = 1'b1;
    q.push_back('{d: 8'h39, c: 3'd4});
    send_beat(2'b01, 1'b0);
    send_beat(2'b10, 1'b0);
    send_beat(2'b11, 1'b0);
    send_beat(2'b00, 1'b0);
    @(negedge clk);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    chk("t1_level_zero", 32'(level), 32'd0);
    step();

    // 2: early flush and single-beat flush from EMPTY
    q.push_back('{d: 8'h07, c: 3'd2});
    q.push_back('{d: 8'h02, c: 3'd1});
    send_beat(2'b11, 1'b0);
    send_beat(2'b01, 1'b1);
    send_beat(2'b10, 1'b1);
    drain();

    // 3: fill to DEPTH under backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back('{d: 8'hFF, c: 3'd4});
    for (int i = 0; i < 16; i++) send_beat(2'b11, 1'b0);
    in_valid = 1'b1;
    in_data  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_full_level", 32'(level), 32'd4);
      chk("t3_full_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_level_after_pop", 32'(level), 32'd3);
    chk("t3_in_ready_after_pop", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b1;
    drain();

    // 4: streaming across pointer wrap
    stream = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = (i % 2 == 0) ? 8'hA5 : 8'h5A;
      q.push_back('{d: w, c: 3'd4});
      for (int k = 0; k < 4; k++) send_beat(w[k*2 +: 2], 1'b0);
    end
    stream = 1'b0;
    drain();

    // 5: reset discards a partial word
    send_beat(2'b01, 1'b0);
    send_beat(2'b01, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    step();
    q.push_back('{d: 8'hAA, c: 3'd4});
    for (int i = 0; i < 4; i++) send_beat(2'b10, 1'b0);
    drain();

    // 6: head stable under backpressure
    out_ready = 1'b0;
    q.push_back('{d: 8'h55, c: 3'd4});
    for (int i = 0; i < 4; i++) send_beat(2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_hold_data", 32'(out_data), 32'h55);
      chk("t6_hold_count", 32'(out_count), 32'd4);
      chk("t6_hold_level", 32'(level), 32'd1);
      step();
    end
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
